btn_pulse_gen: RTL and testbench

//   Multi-channel push-button conditioner: synchronises raw btn inputs, debounces them
//   in the clk domain and emits one-cycle press/release strobes plus optional

---
 rtl/btn_pulse_gen_if.sv | 26 ++
 rtl/btn_pulse_gen.sv | 142 ++++++++++++++
 tb/tb_btn_pulse_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/btn_pulse_gen_if.sv
// Button conditioner bundle: raw buttons and repeat enables in, debounced level and strobes out.
interface btn_pulse_gen_if #(
    parameter int N = 3
);
    logic [N-1:0] btn_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    modport master (
        output btn_in,
        output repeat_en,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        input  repeat_en,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Per-channel sync + debounce + auto-repeat; press/release strobes registered, DB_CYCLES+2 edges after first sample.
// No backpressure: strobes are single-cycle clock enables for downstream registers.
module btn_pulse_gen #(
    parameter int N         = 3,
    parameter int CNT_W     = 20,
    parameter int DB_CYCLES = 1000000,
    parameter int HOLD_CYC  = 50000000,
    parameter int RATE_CYC  = 20000000
) (
    input  logic             clk,
    input  logic             rst_n,
    btn_pulse_gen_if.slave   btn_if
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS_DB = 3'd1;
    localparam logic [2:0] ST_HELD     = 3'd2;
    localparam logic [2:0] ST_REPEAT   = 3'd3;
    localparam logic [2:0] ST_REL_DB   = 3'd4;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [N-1:0] level_w;
    logic [N-1:0] press_w;
    logic [N-1:0] release_w;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic             s1_q, s2_q;
        logic [2:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1_q      <= btn_if.btn_in[g];
                s2_q      <= s1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Counter restarts from zero on every state change; only s2 is trusted.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s2_q) begin
                        state_d = ST_PRESS_DB;
                        cnt_d   = '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!s2_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s2_q) begin
                        state_d = ST_REL_DB;
                        cnt_d   = '0;
                    end else if (btn_if.repeat_en[g] && (cnt_q == HOLD_LAST)) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else if (cnt_q != HOLD_LAST) begin
                        // Parks at HOLD_LAST so enabling repeat late fires on the next cycle.
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!s2_q) begin
                        state_d = ST_REL_DB;
                        cnt_d   = '0;
                    end else if (!btn_if.repeat_en[g]) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == RATE_LAST) begin
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_REL_DB: begin
                    if (s2_q) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign level_w[g]   = level_q;
        assign press_w[g]   = press_q;
        assign release_w[g] = release_q;
    end

    assign btn_if.btn_level   = level_w;
    assign btn_if.btn_press   = press_w;
    assign btn_if.btn_release = release_w;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with short timing parameters (DB=4, HOLD=8, RATE=3).
module tb_btn_pulse_gen;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    btn_pulse_gen_if #(.N(N)) bif ();

    btn_pulse_gen #(
        .N(N), .CNT_W(4), .DB_CYCLES(4), .HOLD_CYC(8), .RATE_CYC(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (bif.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;
    int pc [N];
    int rc [N];
    int first_press [N];
    int second_press [N];
    int last_press [N];
    int first_rel [N];
    int c0, c1, cs;
    logic [4:0] pat;

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            pc[i] = 0; rc[i] = 0;
            first_press[i] = -1; second_press[i] = -1;
            last_press[i] = -1; first_rel[i] = -1;
        end
    endtask

    // One clock edge, then observe outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (bif.btn_press[i] === 1'b1) begin
                pc[i]++;
                if (pc[i] == 1) first_press[i] = cyc;
                if (pc[i] == 2) second_press[i] = cyc;
                last_press[i] = cyc;
            end
            if (bif.btn_release[i] === 1'b1) begin
                rc[i]++;
                if (rc[i] == 1) first_rel[i] = cyc;
            end
            if (bif.btn_press[i] === 1'b1 && bif.btn_release[i] === 1'b1) overlap++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bif.btn_in = '0;
        bif.repeat_en = '0;
        clr();

        // 1: reset with buttons held, then release reset
        bif.btn_in = 3'b111;
        repeat (3) tick();
        chk("rst_level", 32'(bif.btn_level), 0);
        chk("rst_press", 32'(bif.btn_press), 0);
        chk("rst_release", 32'(bif.btn_release), 0);
        c0 = cyc;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t1_press_early", 32'(bif.btn_press), 0);
        tick();
        chk("t1_press", 32'(bif.btn_press), 3'b111);
        tick();
        chk("t1_press_width", 32'(bif.btn_press), 0);
        repeat (20) tick();
        chk("t1_press_count", pc[0] + pc[1] + pc[2], 3);
        chk("t1_level", 32'(bif.btn_level), 3'b111);
        chk("t1_no_release", rc[0] + rc[1] + rc[2], 0);
        bif.btn_in = 3'b000;
        repeat (12) tick();
        chk("t1_rel_level", 32'(bif.btn_level), 0);
        chk("t1_rel_count", rc[0] + rc[1] + rc[2], 3);

        // 2: single press/release on ch0
        clr();
        c0 = cyc;
        bif.btn_in = 3'b001;
        repeat (10) tick();
        chk("t2_level_mid", 32'(bif.btn_level), 3'b001);
        repeat (10) tick();
        c1 = cyc;
        bif.btn_in = 3'b000;
        repeat (12) tick();
        chk("t2_press_time", first_press[0], c0 + 7);
        chk("t2_press_count", pc[0], 1);
        chk("t2_rel_time", first_rel[0], c1 + 7);
        chk("t2_rel_count", rc[0], 1);
        chk("t2_others_silent", pc[1] + pc[2] + rc[1] + rc[2], 0);
        chk("t2_level_end", 32'(bif.btn_level), 0);

        // 3: bounce on ch1 then steady press
        clr();
        pat = 5'b11100;
        for (int r = 0; r < 5; r++) begin
            for (int j = 4; j >= 0; j--) begin
                bif.btn_in[1] = pat[j];
                tick();
            end
        end
        repeat (3) tick();
        chk("t3_bounce_press", pc[1], 0);
        chk("t3_bounce_level", 32'(bif.btn_level), 0);
        cs = cyc;
        bif.btn_in[1] = 1'b1;
        repeat (10) tick();
        chk("t3_press_count", pc[1], 1);
        chk("t3_press_time", first_press[1], cs + 7);
        chk("t3_level", 32'(bif.btn_level), 3'b010);
        bif.btn_in = 3'b000;
        repeat (12) tick();

        // 4: auto-repeat on ch2
        clr();
        bif.repeat_en = 3'b100;
        c0 = cyc;
        bif.btn_in = 3'b100;
        repeat (30) tick();
        bif.btn_in = 3'b000;
        repeat (12) tick();
        chk("t4_press_count", pc[2], 7);
        chk("t4_first", first_press[2], c0 + 7);
        chk("t4_second", second_press[2], c0 + 15);
        chk("t4_last", last_press[2], c0 + 30);
        chk("t4_rel_count", rc[2], 1);
        chk("t4_rel_time", first_rel[2], c0 + 37);
        bif.repeat_en = 3'b000;

        // 5: short dropout while held restarts repeat timing
        clr();
        bif.repeat_en = 3'b001;
        c0 = cyc;
        bif.btn_in = 3'b001;
        repeat (9) tick();
        bif.btn_in = 3'b000;
        repeat (2) tick();
        bif.btn_in = 3'b001;
        repeat (3) tick();
        chk("t5_glitch_level", 32'(bif.btn_level), 3'b001);
        chk("t5_glitch_norel", rc[0], 0);
        repeat (12) tick();
        bif.btn_in = 3'b000;
        repeat (12) tick();
        chk("t5_press_count", pc[0], 4);
        chk("t5_first_repeat", second_press[0], c0 + 22);
        chk("t5_last", last_press[0], c0 + 28);
        chk("t5_rel_count", rc[0], 1);
        chk("t5_rel_time", first_rel[0], c0 + 33);
        bif.repeat_en = 3'b000;

        // 6: reset in the middle of repeat on ch2
        clr();
        bif.repeat_en = 3'b100;
        c0 = cyc;
        bif.btn_in = 3'b100;
        repeat (17) tick();
        chk("t6_pre_level", 32'(bif.btn_level), 3'b100);
        chk("t6_pre_count", pc[2], 2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_level", 32'(bif.btn_level), 0);
        chk("t6_async_press", 32'(bif.btn_press), 0);
        tick();
        chk("t6_held_level", 32'(bif.btn_level), 0);
        clr();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t6_no_deassert_strobe", pc[2] + rc[2], 0);
        tick();
        chk("t6_press", 32'(bif.btn_press), 3'b100);
        repeat (3) tick();
        chk("t6_press_count", pc[2], 1);
        chk("t6_level", 32'(bif.btn_level), 3'b100);
        bif.btn_in = 3'b000;
        bif.repeat_en = 3'b000;
        repeat (12) tick();
        chk("t6_rel_count", rc[2], 1);

        chk("press_release_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
